// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: PC widths, reset vector, and
// the state encoding of the PC-generation stage.
package pipe_pkg;

  localparam int DEF_PC_WIDTH   = 32;
  localparam int DEF_JTGT_WIDTH = 26;
  localparam logic [31:0] DEF_RESET_PC = 32'h0;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } pc_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux: branch target, jump address, or PC+1.
// Purely combinational; the jump keeps the upper PC bits.
module next_pc_sel
  import pipe_pkg::*;
#(
  parameter int PC_WIDTH   = DEF_PC_WIDTH,
  parameter int JTGT_WIDTH = DEF_JTGT_WIDTH
) (
  input  logic [PC_WIDTH-1:0]   pc_i,
  input  logic                  br_taken_i,
  input  logic [PC_WIDTH-1:0]   br_target_i,
  input  logic                  jmp_i,
  input  logic [JTGT_WIDTH-1:0] jmp_target_i,
  output logic [PC_WIDTH-1:0]   next_pc_o,
  output logic                  redirect_o
);

  always_comb begin
    next_pc_o  = pc_i + PC_WIDTH'(1);
    redirect_o = 1'b0;
    priority case (1'b1)
      br_taken_i: begin
        next_pc_o  = br_target_i;
        redirect_o = 1'b1;
      end
      jmp_i: begin
        next_pc_o  = {pc_i[PC_WIDTH-1:JTGT_WIDTH], jmp_target_i};
        redirect_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_gen_unit.sv
// PC generation stage: owns the PC, drives a wait-state imem,
// resolves redirects and flushes wrong-path fetches.
module pc_gen_unit
  import pipe_pkg::*;
#(
  parameter int PC_WIDTH   = DEF_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEF_RESET_PC),
  parameter int JTGT_WIDTH = DEF_JTGT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pc_en_in,
  input  logic                  jmp_in,
  input  logic [JTGT_WIDTH-1:0] jmp_target_in,
  input  logic                  br_taken_in,
  input  logic [PC_WIDTH-1:0]   br_target_in,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ready,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic [PC_WIDTH-1:0]   npc_out,
  output logic                  valid_out,
  output logic                  flush_out
);

  pc_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] ptgt_q, ptgt_d;
  logic                pend_q, pend_d;
  logic                req_q, req_d;
  logic [PC_WIDTH-1:0] sel_pc;
  logic                redirect;
  logic                jmp_ok;
  logic                adv;
  logic                valid;

  // Stalled jumps are dropped; decode presents them again.
  assign jmp_ok = jmp_in & pc_en_in;
  assign adv    = pc_en_in | br_taken_in;

  next_pc_sel #(
    .PC_WIDTH  (PC_WIDTH),
    .JTGT_WIDTH(JTGT_WIDTH)
  ) u_sel (
    .pc_i        (pc_q),
    .br_taken_i  (br_taken_in),
    .br_target_i (br_target_in),
    .jmp_i       (jmp_ok),
    .jmp_target_i(jmp_target_in),
    .next_pc_o   (sel_pc),
    .redirect_o  (redirect)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ptgt_d  = ptgt_q;
    pend_d  = pend_q;
    valid   = 1'b0;
    unique case (state_q)
      BOOT: state_d = FETCH;
      FETCH, WAIT: begin
        if (adv) begin
          if (imem_ready) begin
            valid   = 1'b1;
            pc_d    = sel_pc;
            state_d = FETCH;
          end else if (redirect) begin
            // Outstanding fetch cannot be cancelled.
            ptgt_d  = sel_pc;
            pend_d  = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = WAIT;
          end
        end
      end
      DRAIN: begin
        if (redirect) ptgt_d = sel_pc;
        if (imem_ready && pend_q) begin
          pc_d    = ptgt_d;
          pend_d  = 1'b0;
          state_d = FETCH;
        end
      end
    endcase
    req_d = (state_d != BOOT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      ptgt_q  <= RESET_PC;
      pend_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ptgt_q  <= ptgt_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc_out    = pc_q;
  assign npc_out   = pc_q + PC_WIDTH'(1);
  assign valid_out = valid;
  assign flush_out = (br_taken_in | jmp_in) & (state_q != BOOT);

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: cycle vector table plus an
// asynchronous reset-in-WAIT sequence.
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_en_in;
  logic        jmp_in;
  logic [25:0] jmp_target_in;
  logic        br_taken_in;
  logic [31:0] br_target_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] pc_out;
  logic [31:0] npc_out;
  logic        valid_out;
  logic        flush_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_gen_unit dut (
    .clk          (clk),
    .reset        (reset),
    .pc_en_in     (pc_en_in),
    .jmp_in       (jmp_in),
    .jmp_target_in(jmp_target_in),
    .br_taken_in  (br_taken_in),
    .br_target_in (br_target_in),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .pc_out       (pc_out),
    .npc_out      (npc_out),
    .valid_out    (valid_out),
    .flush_out    (flush_out)
  );

  typedef struct {
    logic        en;
    logic        jmp;
    logic [25:0] jt;
    logic        br;
    logic [31:0] bt;
    logic        rdy;
    logic        req;
    logic [31:0] pc;
    logic        vld;
    logic        fl;
  } vec_t;

  localparam int NV = 35;
  vec_t tv[NV];

  function automatic vec_t mk(
    input logic en, input logic jmp, input logic [25:0] jt,
    input logic br, input logic [31:0] bt, input logic rdy,
    input logic req, input logic [31:0] pc,
    input logic vld, input logic fl);
    vec_t v;
    v.en = en; v.jmp = jmp; v.jt = jt; v.br = br; v.bt = bt;
    v.rdy = rdy; v.req = req; v.pc = pc; v.vld = vld; v.fl = fl;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    pc_en_in      = v.en;
    jmp_in        = v.jmp;
    jmp_target_in = v.jt;
    br_taken_in   = v.br;
    br_target_in  = v.bt;
    imem_ready    = v.rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(mk(1, 0, 26'h0, 0, 32'h0, rdy, 0, 32'h0, 0, 0));
  endtask

  initial begin
    // en jmp jt br bt rdy | req pc vld flush
    tv[0]  = mk(1,0,0,0,0,1,            0,32'h0,0,0);
    tv[1]  = mk(1,0,0,0,0,1,            1,32'h0,1,0);
    tv[2]  = mk(1,0,0,0,0,1,            1,32'h1,1,0);
    tv[3]  = mk(1,0,0,0,0,1,            1,32'h2,1,0);
    tv[4]  = mk(1,0,0,0,0,1,            1,32'h3,1,0);
    tv[5]  = mk(1,0,0,0,0,0,            1,32'h4,0,0);
    tv[6]  = mk(1,0,0,0,0,0,            1,32'h4,0,0);
    tv[7]  = mk(1,0,0,0,0,1,            1,32'h4,1,0);
    tv[8]  = mk(1,0,0,0,0,1,            1,32'h5,1,0);
    tv[9]  = mk(1,0,0,1,32'h0400_0010,1,1,32'h6,1,1);
    tv[10] = mk(1,1,26'h100,0,0,1,      1,32'h0400_0010,1,1);
    tv[11] = mk(1,0,0,0,0,1,            1,32'h0400_0100,1,0);
    tv[12] = mk(1,1,26'h80,1,32'h40,1,  1,32'h0400_0101,1,1);
    tv[13] = mk(1,0,0,0,0,1,            1,32'h40,1,0);
    tv[14] = mk(1,0,0,0,0,0,            1,32'h41,0,0);
    tv[15] = mk(1,0,0,1,32'h20,0,       1,32'h41,0,1);
    tv[16] = mk(1,0,0,0,0,1,            1,32'h41,0,0);
    tv[17] = mk(1,0,0,0,0,1,            1,32'h20,1,0);
    tv[18] = mk(1,0,0,1,32'hFFFF_FFFF,1,1,32'h21,1,1);
    tv[19] = mk(1,0,0,0,0,1,            1,32'hFFFF_FFFF,1,0);
    tv[20] = mk(1,0,0,0,0,1,            1,32'h0,1,0);
    tv[21] = mk(0,0,0,0,0,1,            1,32'h1,0,0);
    tv[22] = mk(0,0,0,0,0,1,            1,32'h1,0,0);
    tv[23] = mk(0,0,0,0,0,1,            1,32'h1,0,0);
    tv[24] = mk(1,0,0,0,0,1,            1,32'h1,1,0);
    tv[25] = mk(0,1,26'h300,0,0,1,      1,32'h2,0,1);
    tv[26] = mk(1,0,0,0,0,1,            1,32'h2,1,0);
    tv[27] = mk(0,0,0,1,32'h50,0,       1,32'h3,0,1);
    tv[28] = mk(1,0,0,0,0,1,            1,32'h3,0,0);
    tv[29] = mk(1,0,0,0,0,1,            1,32'h50,1,0);
    tv[30] = mk(1,0,0,0,0,0,            1,32'h51,0,0);
    tv[31] = mk(1,0,0,1,32'h60,0,       1,32'h51,0,1);
    tv[32] = mk(1,1,26'h70,0,0,0,       1,32'h51,0,1);
    tv[33] = mk(1,0,0,0,0,1,            1,32'h51,0,0);
    tv[34] = mk(1,0,0,0,0,1,            1,32'h70,1,0);

    reset = 1'b0;
    idle(1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   0, 32'(imem_req),  32'h0);
    chk("rst_valid", 0, 32'(valid_out), 32'h0);
    chk("rst_flush", 0, 32'(flush_out), 32'h0);
    chk("rst_pc",    0, pc_out,         32'h0);
    chk("rst_npc",   0, npc_out,        32'h1);

    reset = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(tv[i]);
      #4;
      chk("req",   i, 32'(imem_req),  32'(tv[i].req));
      chk("valid", i, 32'(valid_out), 32'(tv[i].vld));
      chk("flush", i, 32'(flush_out), 32'(tv[i].fl));
      if (tv[i].req) chk("addr", i, imem_addr, tv[i].pc);
      if (tv[i].vld) begin
        chk("pc",  i, pc_out,  tv[i].pc);
        chk("npc", i, npc_out, tv[i].pc + 32'd1);
      end
      @(posedge clk);
      #1;
    end

    // pc=0x71: enter WAIT, then reset asynchronously mid-cycle
    idle(1'b0);
    #4;
    chk("w_addr",  0, imem_addr,        32'h71);
    chk("w_valid", 0, 32'(valid_out),   32'h0);
    @(posedge clk);
    #2;
    br_taken_in  = 1'b1;
    br_target_in = 32'h99;
    reset = 1'b0;
    #1;
    chk("ar_req",   0, 32'(imem_req),  32'h0);
    chk("ar_valid", 0, 32'(valid_out), 32'h0);
    chk("ar_flush", 0, 32'(flush_out), 32'h0);
    chk("ar_pc",    0, pc_out,         32'h0);
    chk("ar_npc",   0, npc_out,        32'h1);
    chk("ar_addr",  0, imem_addr,      32'h0);
    idle(1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #4;
    chk("boot_req",   0, 32'(imem_req),  32'h0);
    chk("boot_valid", 0, 32'(valid_out), 32'h0);
    @(posedge clk);
    #5;
    chk("rf_req",   0, 32'(imem_req),  32'h1);
    chk("rf_addr",  0, imem_addr,      32'h0);
    chk("rf_valid", 0, 32'(valid_out), 32'h1);
    @(posedge clk);
    #5;
    chk("rf_addr",  1, imem_addr,      32'h1);
    chk("rf_valid", 1, 32'(valid_out), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
